// File: rtl/lfsr_gen.sv
// LFSR generator: Fibonacci or Galois stepping, load, all-zero lockup
// recovery, and measurement of the sequence length back to a reference.
module lfsr_gen #(
    parameter int unsigned              WIDTH = 16,
    parameter logic [WIDTH-1:0]         FTAPS = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0]         GMASK = WIDTH'(16'h002D),
    parameter logic [WIDTH-1:0]         SEED  = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    logic [WIDTH-1:0] ref_value;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] next_state;
    logic             fib_fb;

    assign bit_out = state[WIDTH-1];

    // Next state for one step in the selected mode, plus saturating count+1
    always_comb begin
        fib_fb    = ^(state & FTAPS);
        next_state = '0;
        if (mode) begin
            next_state = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GMASK : '0);
        end else begin
            next_state = {state[WIDTH-2:0], fib_fb};
        end
        count_inc = (count == '1) ? count : count + WIDTH'(1);
    end

    // State, reference, counter and measurement registers with priority
    // reset > load > lockup recovery > step > hold
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= SEED;
            ref_value    <= SEED;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            lockup       <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                state        <= data;
                ref_value    <= data;
                count        <= '0;
                period_valid <= 1'b0;
            end else if (en) begin
                if (state == '0) begin
                    state     <= SEED;
                    ref_value <= SEED;
                    count     <= '0;
                    lockup    <= 1'b1;
                end else begin
                    state <= next_state;
                    if (next_state == ref_value) begin
                        wrap         <= 1'b1;
                        period       <= count_inc;
                        period_valid <= 1'b1;
                        count        <= '0;
                    end else begin
                        count <= count_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen at WIDTH=4 with a sequence-level model.
module tb_lfsr_gen;

    localparam int unsigned W  = 4;
    localparam logic [3:0]  FT = 4'b1100;
    localparam logic [3:0]  GM = 4'b0011;
    localparam logic [3:0]  SD = 4'b0001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       mode  = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] data  = '0;
    logic [3:0] state;
    logic       bit_out;
    logic       lockup;
    logic       wrap;
    logic [3:0] period;
    logic       period_valid;

    lfsr_gen #(
        .WIDTH(W),
        .FTAPS(FT),
        .GMASK(GM),
        .SEED (SD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .load        (load),
        .data        (data),
        .state       (state),
        .bit_out     (bit_out),
        .lockup      (lockup),
        .wrap        (wrap),
        .period      (period),
        .period_valid(period_valid)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: integer state, reference, step count since reference
    int m_state, m_ref, m_cnt, m_per;
    bit m_pv, m_wrap, m_lock;
    bit model_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One LFSR step computed arithmetically: shift is *2 mod 16
    function automatic int model_step(input int s, input bit galois);
        int t;
        t = (s * 2) % 16;
        if (!galois) begin
            t = t + ($countones(4'(s) & FT) % 2);
        end else if (s >= 8) begin
            t = t ^ int'(GM);
        end
        return t;
    endfunction

    task automatic model_update(input bit r, input bit l, input bit e,
                                input bit md, input int d);
        int nx;
        m_wrap = 1'b0;
        m_lock = 1'b0;
        if (r) begin
            m_state = 1; m_ref = 1; m_cnt = 0; m_per = 0; m_pv = 1'b0;
        end else if (l) begin
            m_state = d; m_ref = d; m_cnt = 0; m_pv = 1'b0;
        end else if (e) begin
            if (m_state == 0) begin
                m_state = 1; m_ref = 1; m_cnt = 0; m_lock = 1'b1;
            end else begin
                nx = model_step(m_state, md);
                m_state = nx;
                if (nx == m_ref) begin
                    m_wrap = 1'b1;
                    m_per  = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
                    m_pv   = 1'b1;
                    m_cnt  = 0;
                end else begin
                    m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle
    task automatic cyc(input bit r, input bit l, input bit e,
                       input bit md, input int d);
        @(negedge clock);
        reset = r; load = l; en = e; mode = md; data = 4'(d);
        @(posedge clock);
        model_update(r, l, e, md, d);
        model_on = 1'b1;
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (model_on) begin
            chk("state",        int'(state),        m_state);
            chk("bit_out",      int'(bit_out),      m_state / 8);
            chk("lockup",       int'(lockup),       int'(m_lock));
            chk("wrap",         int'(wrap),         int'(m_wrap));
            chk("period",       int'(period),       m_per);
            chk("period_valid", int'(period_valid), int'(m_pv));
        end
    end

    initial begin
        int fib_exp[6] = '{2, 4, 9, 3, 6, 13};
        int gal_exp[7] = '{2, 4, 8, 3, 6, 12, 11};

        // Reset values
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_state", int'(state), 1);
        chk("rst_period", int'(period), 0);
        chk("rst_pv", int'(period_valid), 0);

        // Fibonacci sequence and period
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 1, 0, 0);
            if (i <= 6) chk("fib_seq", int'(state), fib_exp[i-1]);
            if (i < 15) chk("fib_nowrap", int'(wrap), 0);
        end
        chk("fib_wrap_state", int'(state), 1);
        chk("fib_wrap", int'(wrap), 1);
        chk("fib_period", int'(period), 15);
        chk("fib_pv", int'(period_valid), 1);
        cyc(0, 0, 1, 0, 0);
        chk("fib_wrap_pulse", int'(wrap), 0);

        // Galois sequence and period
        cyc(1, 0, 0, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 1, 1, 0);
            if (i <= 7) chk("gal_seq", int'(state), gal_exp[i-1]);
        end
        chk("gal_wrap", int'(wrap), 1);
        chk("gal_period", int'(period), 15);

        // Load all-zero then lockup recovery
        cyc(0, 1, 0, 0, 0);
        chk("load0_state", int'(state), 0);
        chk("load0_pv", int'(period_valid), 0);
        cyc(0, 0, 1, 0, 0);
        chk("lock_state", int'(state), 1);
        chk("lock_pulse", int'(lockup), 1);
        chk("lock_nowrap", int'(wrap), 0);
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 1, 0, 0);
            if (i == 1) chk("lock_one_cycle", int'(lockup), 0);
        end
        chk("lock_wrap", int'(wrap), 1);
        chk("lock_period", int'(period), 15);

        // Load with en: no step, counter cleared
        cyc(0, 1, 1, 0, 6);
        chk("load_en_state", int'(state), 6);
        for (int i = 1; i <= 15; i++) cyc(0, 0, 1, 0, 0);
        chk("load_ref_wrap", int'(wrap), 1);
        chk("load_ref_state", int'(state), 6);
        chk("load_ref_period", int'(period), 15);

        // Reset overrides load
        cyc(1, 1, 1, 0, 9);
        chk("rst_over_load", int'(state), 1);

        // Reset overrides lockup recovery
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("rst_over_lock_state", int'(state), 1);
        chk("rst_over_lock_pulse", int'(lockup), 0);

        // Hold: en toggles for 30 cycles
        for (int i = 0; i < 30; i++) cyc(0, 0, (i % 2) == 0, 0, 0);
        chk("hold_state", int'(state), 1);
        chk("hold_period", int'(period), 15);
        chk("hold_wrap", int'(wrap), 0);
        chk("hold_pv", int'(period_valid), 1);

        // Reset mid-run at step 7
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("mid_rst_state", int'(state), 1);
        chk("mid_rst_pv", int'(period_valid), 0);
        chk("mid_rst_period", int'(period), 0);

        // Mode change mid-sequence, tracked by the model
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 25; i++) cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, (i % 3) == 0, 0);

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
